// File: rtl/jtag_tap_master.sv
// JTAG initiator: shifts up to 32 TMS/TDI bits per host command on a
// divided TCK and returns the TDO bits captured at each rising edge.
module jtag_tap_master #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned MAX_LEN = 32
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [5:0]  cmd_len_i,
    input  logic [31:0] cmd_tms_i,
    input  logic [31:0] cmd_tdi_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_tdo_o,
    output logic        busy_o,
    output logic        tck_o,
    output logic        tms_o,
    output logic        tdi_o,
    input  logic        tdo_i
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned LEN_W = 6;
    localparam int unsigned IDX_W = 5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOW,
        S_HIGH,
        S_RESP
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [IDX_W-1:0]   idx_q;
    logic [LEN_W-1:0]   len_q;
    logic [31:0]        tms_vec_q;
    logic [31:0]        tdi_vec_q;
    logic [31:0]        shadow_q;
    logic [1:0]         sync_q;
    logic               tck_q;
    logic               tms_q;
    logic               tdi_q;
    logic               rsp_valid_q;
    logic               ready_q;
    logic               busy_q;

    logic [LEN_W-1:0]   len_d;
    logic               half_done;
    logic               last_bit;

    // Lengths above MAX_LEN are clamped rather than rejected.
    assign len_d     = (cmd_len_i > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cmd_len_i;
    assign half_done = (cnt_q == CNT_W'(CLK_DIV - 1));
    assign last_bit  = ({1'b0, idx_q} == (len_q - LEN_W'(1)));

    // TDO is asynchronous to clk_i.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], tdo_i};
        end
    end

    // Shift engine: LOW and HIGH each last CLK_DIV cycles per bit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            len_q       <= '0;
            tms_vec_q   <= '0;
            tdi_vec_q   <= '0;
            shadow_q    <= '0;
            tck_q       <= 1'b0;
            tms_q       <= 1'b1;
            tdi_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    ready_q <= 1'b1;
                    if (cmd_valid_i && ready_q) begin
                        len_q     <= len_d;
                        tms_vec_q <= cmd_tms_i;
                        tdi_vec_q <= cmd_tdi_i;
                        shadow_q  <= '0;
                        idx_q     <= '0;
                        cnt_q     <= '0;
                        tms_q     <= cmd_tms_i[0];
                        tdi_q     <= cmd_tdi_i[0];
                        ready_q   <= 1'b0;
                        busy_q    <= 1'b1;
                        if (len_d == '0) begin
                            rsp_valid_q <= 1'b1;
                            state_q     <= S_RESP;
                        end else begin
                            state_q <= S_LOW;
                        end
                    end
                end
                S_LOW: begin
                    if (half_done) begin
                        cnt_q           <= '0;
                        tck_q           <= 1'b1;
                        shadow_q[idx_q] <= sync_q[1];
                        state_q         <= S_HIGH;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_HIGH: begin
                    if (half_done) begin
                        cnt_q <= '0;
                        tck_q <= 1'b0;
                        if (last_bit) begin
                            rsp_valid_q <= 1'b1;
                            state_q     <= S_RESP;
                        end else begin
                            idx_q   <= idx_q + IDX_W'(1);
                            tms_q   <= tms_vec_q[idx_q + IDX_W'(1)];
                            tdi_q   <= tdi_vec_q[idx_q + IDX_W'(1)];
                            state_q <= S_LOW;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        ready_q     <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready_o = ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_tdo_o   = shadow_q;
    assign busy_o      = busy_q;
    assign tck_o       = tck_q;
    assign tms_o       = tms_q;
    assign tdi_o       = tdi_q;

endmodule

// File: tb/tb_jtag_tap_master.sv
// Bench for jtag_tap_master: directed and random commands against an
// edge-count timing model and a shift-register TAP that drives TDO.
module tb_jtag_tap_master;

    localparam int unsigned D = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [5:0]  cmd_len;
    logic [31:0] cmd_tms;
    logic [31:0] cmd_tdi;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_tdo;
    logic        busy;
    logic        tck_w;
    logic        tms_w;
    logic        tdi_w;
    logic        tdo_r;

    int total = 0;
    int bad   = 0;

    jtag_tap_master #(.CLK_DIV(D), .MAX_LEN(32)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_len_i   (cmd_len),
        .cmd_tms_i   (cmd_tms),
        .cmd_tdi_i   (cmd_tdi),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_tdo_o   (rsp_tdo),
        .busy_o      (busy),
        .tck_o       (tck_w),
        .tms_o       (tms_w),
        .tdi_o       (tdi_w),
        .tdo_i       (tdo_r)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one command, check every cycle against edge arithmetic, then
    // optionally stall the response (bp also waves a command that must be ignored).
    task automatic run_cmd(input logic [5:0] len, input logic [31:0] tms, input logic [31:0] tdi,
                           input logic [31:0] pat, input int hold, input bit bp);
        int n;
        int last;
        int rises;
        int b;
        logic [31:0] m;
        logic [31:0] sr;
        logic [31:0] otms;
        logic [31:0] otdi;
        logic ptck;
        logic etck;
        logic erv;
        n = (len > 6'd32) ? 32 : int'(len);
        m = 32'((64'd1 << n) - 64'd1);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_len   = len;
        cmd_tms   = tms;
        cmd_tdi   = tdi;
        rsp_ready = 1'b0;
        sr        = pat;
        tdo_r     = pat[0];
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("accept", {27'b0, tck_w, tms_w, tdi_w, busy, cmd_ready},
              {27'b0, 1'b0, tms[0], tdi[0], 1'b1, 1'b0});
        last  = (n == 0) ? 1 : 2 * int'(D) * n;
        rises = 0;
        otms  = '0;
        otdi  = '0;
        ptck  = 1'b0;
        for (int e = 1; e <= last; e++) begin
            @(posedge clk);
            #1;
            if (e < 2 * int'(D) * n) b = e / (2 * int'(D));
            else                      b = (n == 0) ? 0 : n - 1;
            etck = (e < 2 * int'(D) * n) && ((e % (2 * int'(D))) >= int'(D));
            erv  = (e >= 2 * int'(D) * n);
            check("cycle", {26'b0, tck_w, tms_w, tdi_w, rsp_valid, busy, cmd_ready},
                  {26'b0, etck, tms[b], tdi[b], erv, 1'b1, 1'b0});
            if (!ptck && tck_w) begin
                if (rises < 32) begin
                    otms[rises] = tms_w;
                    otdi[rises] = tdi_w;
                end
                rises++;
            end
            if (ptck && !tck_w) begin
                sr    = sr >> 1;
                tdo_r = sr[0];
            end
            ptck = tck_w;
        end
        check("rsp_tdo", rsp_tdo, pat & m);
        check("rises", 32'(rises), 32'(n));
        check("tms_bits", otms, tms & m);
        check("tdi_bits", otdi, tdi & m);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (bp) begin
                cmd_valid = 1'b1;
                cmd_len   = 6'd3;
                cmd_tms   = 32'h7;
                cmd_tdi   = 32'h5;
            end
            @(posedge clk);
            #1;
            check("hold", {28'b0, rsp_valid, tck_w, busy, cmd_ready}, 32'b1010);
            check("hold_tdo", rsp_tdo, pat & m);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("handshake", {28'b0, rsp_valid, busy, cmd_ready, tck_w}, 32'b0010);
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_len   = '0;
        cmd_tms   = '0;
        cmd_tdi   = '0;
        rsp_ready = 1'b0;
        tdo_r     = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out", {26'b0, tck_w, tms_w, tdi_w, rsp_valid, busy, cmd_ready}, 32'b010000);
        check("rst_tdo", rsp_tdo, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel_ready", {31'b0, cmd_ready}, 32'h1);

        run_cmd(6'd5, 32'h1F, 32'h0, 32'h0, 0, 1'b0);
        run_cmd(6'd32, 32'h8000_0000, 32'hDEAD_BEEF, 32'h1234_5678, 0, 1'b0);
        run_cmd(6'd0, $urandom, $urandom, $urandom, 0, 1'b0);
        run_cmd(6'd40, $urandom, $urandom, $urandom, 0, 1'b0);
        run_cmd(6'd1, 32'h0, 32'h1, 32'hFFFF_FFFF, 0, 1'b0);
        run_cmd(6'd8, $urandom, $urandom, $urandom, 10, 1'b1);

        repeat (6) begin
            run_cmd(6'($urandom_range(1, 63)), $urandom, $urandom, $urandom,
                    int'($urandom_range(0, 3)), 1'b0);
        end

        // Reset while TCK is high during bit 7 of a 16-bit shift.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_len   = 6'd16;
        cmd_tms   = $urandom;
        cmd_tdi   = 32'h0000_FFFF;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (2 * D * 7 + D) @(posedge clk);
        #3;
        check("pre_rst_tck", {31'b0, tck_w}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("mid_rst", {26'b0, tck_w, tms_w, tdi_w, rsp_valid, busy, cmd_ready}, 32'b010000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        repeat (12) begin
            @(posedge clk);
            #1;
            check("no_rsp", {29'b0, rsp_valid, tck_w, busy}, 32'b000);
        end
        rsp_ready = 1'b0;
        run_cmd(6'd3, $urandom, $urandom, $urandom, 1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
